// File: rtl/register_file_sb.sv
// 32x32 register file with per-register pending-write scoreboard counters and a sticky protocol-error flag.
// Optional same-cycle write-back bypass on the read ports when REGFILE_BYPASS_EN is defined.
module register_file_sb #(
  parameter int unsigned CNTW = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WEN,
  input  logic [4:0]  wsel,
  input  logic [31:0] wdat,
  input  logic [4:0]  rsel1,
  input  logic [4:0]  rsel2,
  output logic [31:0] rdat1,
  output logic [31:0] rdat2,
  output logic        busy1,
  output logic        busy2,
  input  logic        issue,
  input  logic [4:0]  issue_dst,
  output logic        full,
  output logic        err
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [31:0]     regs_q [32];
  logic [CNTW-1:0] cnt_q  [32];
  logic [CNTW-1:0] cnt_d  [32];
  logic            err_q, err_d;
  logic [31:0]     inc_v, dec_v;

  // Entry 0 of both arrays is only ever cleared, so indexing with a zero select yields 0.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (issue) inc_v[issue_dst] = 1'b1;
    if (WEN)   dec_v[wsel]      = 1'b1;
    inc_v[0] = 1'b0;
    dec_v[0] = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    for (int unsigned i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({inc_v[i], dec_v[i]})
        2'b10: begin
          if (cnt_q[i] == CNT_MAX) err_d = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + 1'b1;
        end
        2'b01: begin
          if (cnt_q[i] == '0) err_d = 1'b1;
          else                cnt_d[i] = cnt_q[i] - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (WEN && (wsel != '0)) regs_q[wsel] <= wdat;
      for (int unsigned i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      err_q <= err_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1, byp2;

  // Bypass is suppressed during reset so the read ports stay at zero while RST is held.
  always_comb begin
    byp1  = WEN && !RST && (wsel != '0) && (wsel == rsel1);
    byp2  = WEN && !RST && (wsel != '0) && (wsel == rsel2);
    rdat1 = byp1 ? wdat : regs_q[rsel1];
    rdat2 = byp2 ? wdat : regs_q[rsel2];
    busy1 = (cnt_q[rsel1] != '0) && !(byp1 && (cnt_q[rsel1] == CNTW'(1)));
    busy2 = (cnt_q[rsel2] != '0) && !(byp2 && (cnt_q[rsel2] == CNTW'(1)));
  end
`else
  always_comb begin
    rdat1 = regs_q[rsel1];
    rdat2 = regs_q[rsel2];
    busy1 = (cnt_q[rsel1] != '0);
    busy2 = (cnt_q[rsel2] != '0);
  end
`endif

  assign full = (cnt_q[issue_dst] == CNT_MAX);
  assign err  = err_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: directed scenarios plus randomized traffic against an array model.
module tb_register_file_sb;

  localparam int CNTW = 2;
  localparam int MAXC = (1 << CNTW) - 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WEN = 1'b0;
  logic [4:0]  wsel = '0;
  logic [31:0] wdat = '0;
  logic [4:0]  rsel1 = '0, rsel2 = '0;
  logic [31:0] rdat1, rdat2;
  logic        busy1, busy2;
  logic        issue = 1'b0;
  logic [4:0]  issue_dst = '0;
  logic        full, err;

  register_file_sb #(.CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2),
    .busy1(busy1), .busy2(busy2), .issue(issue), .issue_dst(issue_dst),
    .full(full), .err(err)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    int          step;
    logic [31:0] r1, r2;
    logic        b1, b2, f, e;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step  = 0;

  // Reference state: register contents, outstanding-write counts, sticky error.
  logic [31:0] mem [32];
  int          pend [32];
  bit          merr;

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      mem[i]  = '0;
      pend[i] = 0;
    end
    merr = 1'b0;
  endfunction

  function automatic bit bypass_hit(input logic [4:0] r);
`ifdef REGFILE_BYPASS_EN
    return WEN && (wsel != 0) && (wsel == r);
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.step = step;
    e.r1 = bypass_hit(rsel1) ? wdat : mem[rsel1];
    e.r2 = bypass_hit(rsel2) ? wdat : mem[rsel2];
    e.b1 = (rsel1 != 0) && (pend[rsel1] > 0) && !(bypass_hit(rsel1) && pend[rsel1] == 1);
    e.b2 = (rsel2 != 0) && (pend[rsel2] > 0) && !(bypass_hit(rsel2) && pend[rsel2] == 1);
    e.f  = (issue_dst != 0) && (pend[issue_dst] == MAXC);
    e.e  = merr;
    return e;
  endfunction

  function automatic void model_edge(input bit w, input logic [4:0] ws, input logic [31:0] wd,
                                     input bit is, input logic [4:0] d);
    bit do_inc = is && (d != 0);
    bit do_dec = w && (ws != 0);
    if (do_dec) mem[ws] = wd;
    if (do_inc && do_dec && d == ws) return;
    if (do_inc) begin
      if (pend[d] == MAXC) merr = 1'b1;
      else pend[d]++;
    end
    if (do_dec) begin
      if (pend[ws] == 0) merr = 1'b1;
      else pend[ws]--;
    end
  endfunction

  task automatic cycle(input bit w, input logic [4:0] ws, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input bit is, input logic [4:0] d);
    @(negedge CLK);
    WEN = w; wsel = ws; wdat = wd; rsel1 = r1; rsel2 = r2; issue = is; issue_dst = d;
    #1;
    step++;
    q.push_back(predict());
    -> chk_ev;
    @(posedge CLK);
    model_edge(w, ws, wd, is, d);
  endtask

  // Asserts reset between edges with live traffic on the inputs; outputs must drop at once.
  task automatic reset_pulse(input logic [4:0] r1);
    exp_t e;
    @(negedge CLK);
    WEN = 1'b1; wsel = r1; wdat = 32'hFFFF_0000; rsel1 = r1; rsel2 = 5'd7;
    issue = 1'b1; issue_dst = r1;
    #4;
    RST = 1'b1;
    #1;
    step++;
    e.step = step; e.r1 = '0; e.r2 = '0; e.b1 = 1'b0; e.b2 = 1'b0; e.f = 1'b0; e.e = 1'b0;
    q.push_back(e);
    -> chk_ev;
    model_clear();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    WEN = 1'b0; issue = 1'b0;
  endtask

  task automatic check(input string nm, input int s, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s step %0d got %h want %h", nm, s, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        check("rdat1", e.step, rdat1, e.r1);
        check("rdat2", e.step, rdat2, e.r2);
        check("busy1", e.step, 32'(busy1), 32'(e.b1));
        check("busy2", e.step, 32'(busy2), 32'(e.b2));
        check("full",  e.step, 32'(full),  32'(e.f));
        check("err",   e.step, 32'(err),   32'(e.e));
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  function automatic logic [4:0] rnd_reg();
    return ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
  endfunction

  initial begin : stim
    model_clear();
    // Outputs held at zero while reset is asserted from time zero.
    #3;
    WEN = 1'b1; wsel = 5'd3; wdat = 32'h1111_2222; rsel1 = 5'd3; issue = 1'b1; issue_dst = 5'd3;
    #1;
    q.push_back('{0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    -> chk_ev;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0; WEN = 1'b0; issue = 1'b0;

    // Write then read back; register 0 reads zero.
    cycle(1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 0, 5'd0);
    cycle(0, 5'd0, 32'h0,         5'd5, 5'd0, 0, 5'd0);
    reset_pulse(5'd0);

    // Writes to register 0 are discarded and raise no error.
    cycle(1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 0, 5'd0);
    cycle(0, 5'd0, 32'h0,         5'd0, 5'd0, 1, 5'd0);
    cycle(0, 5'd0, 32'h0,         5'd0, 5'd0, 0, 5'd0);
    reset_pulse(5'd2);

    // Counter saturation on register 7, overflow error, then drain.
    for (int i = 0; i < 3; i++) cycle(0, 5'd0, 32'h0, 5'd7, 5'd0, 1, 5'd7);
    cycle(0, 5'd0, 32'h0, 5'd7, 5'd0, 1, 5'd7);
    for (int i = 0; i < 3; i++) cycle(1, 5'd7, 32'h700 + 32'(i), 5'd7, 5'd1, 0, 5'd7);
    cycle(0, 5'd0, 32'h0, 5'd7, 5'd0, 0, 5'd7);
    reset_pulse(5'd7);

    // Same-cycle issue and retire on register 9 cancel out.
    cycle(0, 5'd0, 32'h0,         5'd9, 5'd0, 1, 5'd9);
    cycle(1, 5'd9, 32'h9999_0000, 5'd9, 5'd9, 1, 5'd9);
    cycle(0, 5'd0, 32'h0,         5'd9, 5'd9, 0, 5'd0);
    // Independent issue and retire to different registers.
    cycle(1, 5'd9, 32'h9999_0001, 5'd9, 5'd10, 1, 5'd10);
    cycle(0, 5'd0, 32'h0,         5'd9, 5'd10, 0, 5'd10);
    reset_pulse(5'd9);

    // Retire into a single pending write with a matching read select.
    cycle(0, 5'd0, 32'h0,         5'd3, 5'd3, 1, 5'd3);
    cycle(1, 5'd3, 32'h1234_5678, 5'd3, 5'd0, 0, 5'd0);
    cycle(0, 5'd0, 32'h0,         5'd3, 5'd0, 0, 5'd0);
    reset_pulse(5'd3);

    // Pending count 2 and an error, cleared by reset landing between edges.
    for (int i = 0; i < 3; i++) cycle(0, 5'd0, 32'h0, 5'd4, 5'd0, 1, 5'd4);
    cycle(1, 5'd4, 32'hA5A5_A5A5, 5'd4, 5'd0, 0, 5'd4);
    cycle(1, 5'd6, 32'h6666_6666, 5'd4, 5'd6, 0, 5'd0);
    cycle(0, 5'd0, 32'h0,         5'd4, 5'd6, 0, 5'd4);
    reset_pulse(5'd4);
    cycle(0, 5'd0, 32'h0,         5'd4, 5'd6, 0, 5'd4);

    // Randomized traffic concentrated on a few registers so saturation and underflow occur.
    for (int n = 0; n < 600; n++) begin
      if ($urandom % 60 == 0) reset_pulse(rnd_reg());
      else cycle(($urandom % 2) == 1, rnd_reg(), $urandom, rnd_reg(), rnd_reg(),
                 ($urandom % 3) != 0, rnd_reg());
    end

    @(negedge CLK);
    #5;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 Parameter CNTW, default 2: width of each per-register pending-write counter; maximum in-flight writes per register is 2^CNTW-1.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 WEN  input  1  write-back write enable (retire).
REQ-005 wsel  input  5  (regbits_t) write-back destination register.
REQ-006 wdat  input  32  (word_t) write-back data.
REQ-007 rsel1, rsel2  input  5 each  read-port register selects.
REQ-008 rdat1, rdat2  output  32 each  read data.
REQ-009 busy1, busy2  output  1 each  source register has an unretired write outstanding.
REQ-010 issue  input  1  decode issued an instruction that will write issue_dst.
REQ-011 issue_dst  input  5  destination of issued instruction.
REQ-012 full  output  1  counter for issue_dst is at maximum; decode stalls.
REQ-013 err  output  1  sticky protocol-error flag.

Function
REQ-014 The block SHALL hold 32 registers of 32 bits; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-015 On a rising edge with WEN=1 and wsel!=0, reg[wsel] SHALL take wdat; visible on rdat the following cycle.
REQ-016 rdat1/rdat2 SHALL be combinational from the array and rsel1/rsel2, with zero added cycles of latency.
REQ-017 Each register 1..31 SHALL carry a CNTW-bit counter: issue with issue_dst!=0 increments, WEN with wsel!=0 decrements, both to the same register in one cycle leaves it unchanged.
REQ-018 busyN SHALL equal (cnt[rselN]!=0) and SHALL be 0 when rselN=0.
REQ-019 full SHALL equal (cnt[issue_dst]==2^CNTW-1) and SHALL be 0 when issue_dst=0.
REQ-020 issue while full=1 and no same-cycle retire to issue_dst SHALL leave the counter unchanged and set err.
REQ-021 WEN to wsel!=0 with cnt[wsel]==0 and no same-cycle issue to wsel SHALL still write data, leave the counter at 0, and set err.
REQ-022 Issue and retire to different registers in one cycle SHALL update both counters independently.
REQ-023 err SHALL remain 1 until reset.
REQ-024 issue or WEN targeting register 0 SHALL have no effect on any counter or err.

Reset
REQ-025 RST=1 SHALL asynchronously clear all 32 registers, all counters and err; rdat1/rdat2=0, busy1/busy2=0, full=0, err=0 while RST is held.
REQ-026 RST asserted mid-operation SHALL discard all outstanding pending counts; WEN, issue and writes arriving in the same cycle SHALL be ignored.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN defined: when WEN=1, wsel!=0 and wsel==rselN, rdatN SHALL equal wdat in the same cycle, and busyN SHALL be 0 if cnt[rselN]==1.
REQ-028 Macro REGFILE_BYPASS_EN undefined: rdatN SHALL be the array contents only, and busyN SHALL follow REQ-018 with no retire adjustment.

Verification
REQ-029 Reset, WEN=1 wsel=5 wdat=0xDEADBEEF, then rsel1=5 -> rdat1=0xDEADBEEF next cycle; rsel2=0 -> rdat2=0.
REQ-030 WEN=1 wsel=0 wdat=0xFFFFFFFF, then rsel1=0 -> rdat1=0, err=0, no counter changes.
REQ-031 issue to reg 7 three times (CNTW=2) -> full=1 with issue_dst=7; fourth issue -> err=1; three retires to 7 -> busy1=0 for rsel1=7.
REQ-032 Same-cycle issue and WEN to reg 9 with cnt=1 -> cnt stays 1, busy1=1 for rsel1=9, err=0.
REQ-033 REGFILE_BYPASS_EN defined, cnt[3]=1, WEN=1 wsel=3 wdat=0x12345678, rsel1=3 -> same cycle rdat1=0x12345678, busy1=0; undefined -> old value, busy1=1.
REQ-034 cnt[4]=2, reg4=0xA5A5A5A5, err=1, assert RST asynchronously between edges -> immediately rdat1=0 for rsel1=4, busy1=0, err=0.
